// File: rtl/lzw_decoder.sv
// LZW decompressor: fetches codes from a code RAM, rebuilds the dictionary and writes chars to an output RAM.
// Optional `LZW_DEC_ERR_CHECK_EN` rejects codes not yet present in the dictionary.
module lzw_decoder #(
  parameter int ADDR_WIDTH       = 4,
  parameter int VOCAB_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH       = 8,
  parameter int LIT_COUNT        = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cs,
  input  logic [ADDR_WIDTH:0]         code_count,
  output logic [ADDR_WIDTH-1:0]       code_addr,
  input  logic [VOCAB_ADDR_WIDTH-1:0] code_rdata,
  output logic                        out_we,
  output logic [ADDR_WIDTH-1:0]       out_addr,
  output logic [DATA_WIDTH-1:0]       out_wdata,
  output logic [ADDR_WIDTH:0]         out_len,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int DICT_SIZE = 2**VOCAB_ADDR_WIDTH;
  localparam int DEPTH     = DICT_SIZE + 1;
  localparam int SPW       = $clog2(DEPTH + 1);
  localparam int NFW       = VOCAB_ADDR_WIDTH + 1;
  localparam logic [NFW-1:0]        NF_INIT = NFW'(LIT_COUNT);
  localparam logic [NFW-1:0]        NF_FULL = NFW'(DICT_SIZE);
  localparam logic [ADDR_WIDTH:0]   LEN_MAX = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_WALK, S_EMIT, S_UPDATE, S_DONE, S_ERROR
  } state_t;

  state_t                        r_state, w_next;
  logic [ADDR_WIDTH:0]           r_count, r_idx, r_out_len;
  logic [VOCAB_ADDR_WIDTH-1:0]   r_cur, r_code, r_prev;
  logic [DATA_WIDTH-1:0]         r_first;
  logic                          r_kwk;
  logic [NFW-1:0]                r_next_free;
  logic [SPW-1:0]                r_sp;
  logic [VOCAB_ADDR_WIDTH-1:0]   r_pre   [DICT_SIZE];
  logic [DATA_WIDTH-1:0]         r_suf   [DICT_SIZE];
  logic [DATA_WIDTH-1:0]         r_stack [DEPTH];

  logic                  w_cur_lit, w_kwk_hit, w_code_bad, w_stack_empty, w_ovf, w_push;
  logic [NFW-1:0]        w_rdata_ext;
  logic [SPW-1:0]        w_top_idx;
  logic [DATA_WIDTH-1:0] w_push_data;

  assign w_rdata_ext   = {1'b0, code_rdata};
  assign w_cur_lit     = ({1'b0, r_cur} < NF_INIT);
  assign w_kwk_hit     = (r_idx != '0) && (w_rdata_ext == r_next_free);
  assign w_stack_empty = (r_sp == '0);
  assign w_ovf         = (r_out_len == LEN_MAX);
  assign w_top_idx     = r_sp - 1'b1;

`ifdef LZW_DEC_ERR_CHECK_EN
  assign w_code_bad = (w_rdata_ext > r_next_free) ||
                      ((w_rdata_ext == r_next_free) && (r_idx == '0));
`else
  assign w_code_bad = 1'b0;
`endif

  // KwKwK pushes the previous first char before walking prev, so it lands last in output order
  assign w_push      = (r_state == S_WALK) && cs;
  assign w_push_data = r_kwk     ? r_first :
                       w_cur_lit ? DATA_WIDTH'(r_cur) : r_suf[r_cur];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    out_we = 1'b0;
    case (r_state)
      S_IDLE:   if (cs) w_next = (code_count == '0) ? S_DONE : S_FETCH;
      S_FETCH:  w_next = S_WAIT;
      S_WAIT:   w_next = w_code_bad ? S_ERROR : S_WALK;
      S_WALK:   if (!r_kwk && w_cur_lit) w_next = S_EMIT;
      S_EMIT: begin
        if (w_stack_empty) w_next = S_UPDATE;
        else if (w_ovf)    w_next = S_ERROR;
        else               out_we = cs;
      end
      S_UPDATE: w_next = ((r_idx + 1'b1) == r_count) ? S_DONE : S_FETCH;
      S_DONE, S_ERROR: w_next = r_state;
      default:  w_next = S_IDLE;
    endcase
    if (!cs) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_idx       <= '0;
      r_out_len   <= '0;
      r_cur       <= '0;
      r_code      <= '0;
      r_prev      <= '0;
      r_first     <= '0;
      r_kwk       <= 1'b0;
      r_next_free <= NF_INIT;
      r_sp        <= '0;
      for (int unsigned i = 0; i < DICT_SIZE; i++) begin
        r_pre[i] <= '0;
        r_suf[i] <= '0;
      end
    end else if (w_next == S_IDLE) begin
      r_idx       <= '0;
      r_out_len   <= '0;
      r_kwk       <= 1'b0;
      r_next_free <= NF_INIT;
      r_sp        <= '0;
      for (int unsigned i = 0; i < DICT_SIZE; i++) begin
        r_pre[i] <= '0;
        r_suf[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_count <= code_count;
          r_idx   <= '0;
        end
        S_WAIT: begin
          r_code <= code_rdata;
          r_cur  <= w_kwk_hit ? r_prev : code_rdata;
          r_kwk  <= w_kwk_hit;
        end
        S_WALK: begin
          r_sp <= r_sp + 1'b1;
          if (r_kwk)           r_kwk   <= 1'b0;
          else if (!w_cur_lit) r_cur   <= r_pre[r_cur];
          else                 r_first <= DATA_WIDTH'(r_cur);
        end
        S_EMIT: begin
          if (out_we) begin
            r_sp      <= r_sp - 1'b1;
            r_out_len <= r_out_len + 1'b1;
          end
        end
        S_UPDATE: begin
          if ((r_idx != '0) && (r_next_free < NF_FULL)) begin
            r_pre[r_next_free[VOCAB_ADDR_WIDTH-1:0]] <= r_prev;
            r_suf[r_next_free[VOCAB_ADDR_WIDTH-1:0]] <= r_first;
            r_next_free <= r_next_free + 1'b1;
          end
          r_prev <= r_code;
          r_idx  <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_sp] <= w_push_data;
  end

  assign code_addr = r_idx[ADDR_WIDTH-1:0];
  assign out_addr  = r_out_len[ADDR_WIDTH-1:0];
  assign out_wdata = out_we ? r_stack[w_top_idx] : '0;
  assign out_len   = r_out_len;
  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
  assign done      = (r_state == S_DONE);
  assign err       = (r_state == S_ERROR);

endmodule

// File: tb/tb_lzw_decoder.sv
// Self-checking bench for lzw_decoder: a reference LZW decoder fills a scoreboard of expected writes.
module tb_lzw_decoder;

  localparam int AW      = 6;
  localparam int VW      = 5;
  localparam int DW      = 8;
  localparam int LIT     = 8;
  localparam int OUT_MAX = 2**AW;
  localparam int DICT    = 2**VW;

  logic          clk = 1'b0;
  logic          rst_n, cs;
  logic [AW:0]   code_count;
  logic [AW-1:0] code_addr;
  logic [VW-1:0] code_rdata;
  logic          out_we;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_wdata;
  logic [AW:0]   out_len;
  logic          busy, done, err;

  always #5 clk = ~clk;

  lzw_decoder #(
    .ADDR_WIDTH(AW), .VOCAB_ADDR_WIDTH(VW), .DATA_WIDTH(DW), .LIT_COUNT(LIT)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .code_count(code_count),
    .code_addr(code_addr), .code_rdata(code_rdata),
    .out_we(out_we), .out_addr(out_addr), .out_wdata(out_wdata),
    .out_len(out_len), .busy(busy), .done(done), .err(err)
  );

  logic [VW-1:0] code_mem [OUT_MAX];
  always @(posedge clk) code_rdata <= code_mem[code_addr];

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q [$];
  int m_lat, m_len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: entries are {addr, data}
  always @(negedge clk) begin
    if (rst_n && out_we) begin
      if (exp_q.size() == 0) check("unexpected_write", 32'({out_addr, out_wdata}), 32'hFFFF_FFFF);
      else                   check("write", 32'({out_addr, out_wdata}), exp_q.pop_front());
    end
  end

  // Reference decoder over the first n codes of code_mem
  task automatic expect_run(input int n);
    int pre [DICT];
    int suf [DICT];
    int nf = LIT;
    int prev = 0;
    int s [$];
    int c;
    bit kwk;
    m_lat = 1;
    m_len = 0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      c   = int'(code_mem[i]);
      kwk = (i > 0) && (c == nf);
      if (kwk) c = prev;
      s.delete();
      while (c >= LIT) begin
        s.push_front(suf[c]);
        c = pre[c];
      end
      s.push_front(c);
      if (kwk) s.push_back(s[0]);
      m_lat += 4 + 2 * s.size();
      foreach (s[k]) begin
        if (m_len < OUT_MAX) exp_q.push_back(32'((m_len << 8) | s[k]));
        m_len++;
      end
      if (i > 0 && nf < DICT) begin
        pre[nf] = prev;
        suf[nf] = s[0];
        nf++;
      end
      prev = int'(code_mem[i]);
    end
  endtask

  task automatic start_run(input int n, output int cyc);
    cyc = 0;
    @(negedge clk);
    code_count = (AW+1)'(n);
    cs = 1'b1;
    while (!(done || err) && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("finished", 32'(done | err), 32'd1);
  endtask

  task automatic end_run;
    @(negedge clk);
    cs = 1'b0;
    @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_err",  32'(err),  32'd0);
    check("idle_len",  32'(out_len), 32'd0);
    exp_q.delete();
  endtask

  task automatic run(input int n_model, input int n_count, input bit exp_err, input int exp_len);
    int cyc;
    expect_run(n_model);
    start_run(n_count, cyc);
    check("done", 32'(done), 32'(!exp_err));
    check("err",  32'(err),  32'(exp_err));
    check("busy", 32'(busy), 32'd0);
    check("out_len", 32'(out_len), 32'(exp_len));
    if (!exp_err) check("latency", 32'(cyc), 32'(m_lat));
    check("pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load(input int vals [$]);
    foreach (vals[i]) code_mem[i] = VW'(vals[i]);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    cs = 1'b0;
    code_count = '0;
    for (int i = 0; i < OUT_MAX; i++) code_mem[i] = '0;
    #12;
    check("rst_we",   32'(out_we),   32'd0);
    check("rst_len",  32'(out_len),  32'd0);
    check("rst_busy", 32'(busy),     32'd0);
    check("rst_done", 32'(done),     32'd0);
    check("rst_err",  32'(err),      32'd0);
    check("rst_addr", 32'(code_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // KwKwK example: 1,2,1,2,1,2,1
    load('{1, 2, 8, 10});
    run(4, 4, 1'b0, 7);
    end_run();

    // Zero-length job finishes one cycle after cs
    run(0, 0, 1'b0, 0);
    end_run();

    // Fill and freeze the dictionary, then decode entries made early and late
    for (int i = 0; i < 26; i++) code_mem[i] = VW'(i % 8);
    load('{0,1,2,3,4,5,6,7,0,1,2,3,4,5,6,7,0,1,2,3,4,5,6,7,0,1, 31, 30, 9, 8});
    run(30, 30, 1'b0, 34);
    check("next_free_sat", 32'(u_dut.r_next_free), 32'(DICT));
    end_run();

    // Abort while the third char is being emitted, then rerun
    load('{1, 2, 8, 10});
    expect_run(4);
    @(negedge clk);
    code_count = (AW+1)'(4);
    cs = 1'b1;
    cyc = 0;
    while (!(out_we && out_addr == AW'(2)) && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("abort_reached", 32'(out_we && out_addr == AW'(2)), 32'd1);
    cs = 1'b0;
    #1;
    check("abort_we_now", 32'(out_we), 32'd0);
    @(posedge clk);
    #1;
    check("abort_we",   32'(out_we), 32'd0);
    check("abort_busy", 32'(busy),   32'd0);
    check("abort_len",  32'(out_len), 32'd0);
    exp_q.delete();
    run(4, 4, 1'b0, 7);
    end_run();

    // Output overflow: 67 chars into a 64-entry output RAM
    load('{1, 2, 8, 10, 11, 12, 13, 14, 15, 16, 17, 18});
    run(12, 12, 1'b1, OUT_MAX);
    end_run();

`ifdef LZW_DEC_ERR_CHECK_EN
    // Code beyond next_free: first char written, then error
    load('{1, 12});
    run(1, 2, 1'b1, 1);
    end_run();
    // First code equal to next_free is invalid
    load('{8});
    run(0, 1, 1'b1, 0);
    end_run();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
